// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch port with a fixed access
// latency, plus a word-wide preload write port usable in any state.
module imem_responder #(
  parameter int                ADDR_W     = 64,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                LATENCY    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WA_W  = ADDR_W - 2;   // word-address width

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    err_q;

  // Offsets are taken on word addresses; BASE_ADDR is word aligned, so this
  // equals (addr - BASE_ADDR) >> 2 modulo 2^ADDR_W.
  logic [WA_W-1:0]         req_word, wr_word;
  logic                    req_err, wr_hit;
  logic                    accept, rsp_load;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    rd_err;
  logic                    unused_wr_lsb;

  assign req_word = req_addr_i[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
  assign wr_word  = wr_addr_i[ADDR_W-1:2]  - BASE_ADDR[ADDR_W-1:2];

  // Misaligned, or word offset beyond the array (covers below-base wrap too).
  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_word[WA_W-1:DEPTH_LOG2] != '0);
  assign wr_hit  = (wr_word[WA_W-1:DEPTH_LOG2] == '0);

  // Preload byte lanes are ignored; a write always covers the full word.
  assign unused_wr_lsb = ^wr_addr_i[1:0];

  assign accept      = (state == IDLE) && req_valid_i;
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  // With a single-cycle latency RESP is entered on the accept edge itself, so
  // the read must use the live request rather than the latched one.
  assign rd_idx = (state == IDLE) ? req_word[DEPTH_LOG2-1:0] : idx_q;
  assign rd_err = (state == IDLE) ? req_err : err_q;

  // State and latency counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; rsp_load marks the RESP entry edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rsp_load  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            rsp_load  = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          rsp_load  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture word index and fault status of the accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      idx_q <= req_word[DEPTH_LOG2-1:0];
      err_q <= req_err;
    end
  end

  // Response registers load once on RESP entry and then hold; a preload to
  // the same word on that edge is not yet visible, so the old word returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else if (rsp_load) begin
      rsp_data_o <= rd_err ? '0 : mem[rd_idx];
      rsp_err_o  <= rd_err;
    end
  end

  // Preload write port; out-of-range addresses are dropped. Not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_hit) mem[wr_word[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

endmodule
